// File: rtl/fpu_share_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for the FPU share controller.
package fpu_share_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    // Fixed-point unit opcodes
    localparam logic [OP_W-1:0] FPU_ADD  = 2'd0;
    localparam logic [OP_W-1:0] FPU_SUB  = 2'd1;
    localparam logic [OP_W-1:0] FPU_MUL  = 2'd2;
    localparam logic [OP_W-1:0] FPU_SQRT = 2'd3;

    // Opcode presented to the unit while nothing is in flight
    localparam logic [OP_W-1:0] FPU_PARK_OP = FPU_ADD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/fpu_share_ctrl_if.sv
// Requester, response and unit-side signals of the FPU share controller.
interface fpu_share_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic [1:0]       req0_op;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_ready;
    logic             req1_ready;

    logic             resp0_valid;
    logic             resp1_valid;
    logic             resp0_ready;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp0_result;
    logic [WIDTH-1:0] resp1_result;
    logic             resp0_error;
    logic             resp1_error;

    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;

    logic             busy;
    logic             grant_id;

    // Controller side
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp0_result, resp1_result,
        output resp0_error, resp1_error,
        input  resp0_ready, resp1_ready,
        output fpu_operand_1, fpu_operand_2, fpu_operation,
        input  fpu_result, fpu_ready,
        output busy, grant_id
    );

    // Requesters and unit side
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp0_result, resp1_result,
        input  resp0_error, resp1_error,
        output resp0_ready, resp1_ready,
        input  fpu_operand_1, fpu_operand_2, fpu_operation,
        output fpu_result, fpu_ready,
        input  busy, grant_id
    );

endinterface

// File: rtl/fpu_share_ctrl_rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is granted.
module rr_arbiter_2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; last_i=1 means requester 1 won the previous round
    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = {req1_i, req0_i};
        end
    end

endmodule

// File: rtl/fpu_share_ctrl.sv
// Sequences operations from two requesters onto the shared fixed-point unit,
// with a stale-ready settle window and a timeout watchdog.
module fpu_share_ctrl
    import fpu_share_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    fpu_share_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] opnd1_q, opnd1_d;
    logic [WIDTH-1:0] opnd2_q, opnd2_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             resp0_vld_q, resp0_vld_d;
    logic             resp1_vld_q, resp1_vld_d;
    logic             busy_q, busy_d;

    logic [1:0]       arb_gnt;
    logic [1:0]       req_rdy_c;
    logic             own_resp_rdy;

    rr_arbiter_2 u_arb (
        .req0_i (bus.req0_valid),
        .req1_i (bus.req1_valid),
        .last_i (grant_q),
        .gnt_o  (arb_gnt)
    );

    assign own_resp_rdy = grant_q ? bus.resp1_ready : bus.resp0_ready;

    // Next-state, counter and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        result_d    = result_q;
        error_d     = error_q;
        opnd1_d     = opnd1_q;
        opnd2_d     = opnd2_q;
        op_d        = op_q;
        resp0_vld_d = resp0_vld_q;
        resp1_vld_d = resp1_vld_q;
        req_rdy_c   = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                req_rdy_c = arb_gnt;
                if (arb_gnt != 2'b00) begin
                    state_d = ST_WAIT;
                    grant_d = arb_gnt[1];
                    cnt_d   = '0;
                    opnd1_d = arb_gnt[1] ? bus.req1_a  : bus.req0_a;
                    opnd2_d = arb_gnt[1] ? bus.req1_b  : bus.req0_b;
                    op_d    = arb_gnt[1] ? bus.req1_op : bus.req0_op;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Completion wins over timeout when both land on the same cycle
                if ((cnt_q >= CNT_SETTLE) && bus.fpu_ready) begin
                    state_d  = ST_RESP;
                    result_d = bus.fpu_result;
                    error_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_RESP;
                    result_d = '0;
                    error_d  = 1'b1;
                end
                if (state_d == ST_RESP) begin
                    opnd1_d     = '0;
                    opnd2_d     = '0;
                    op_d        = FPU_PARK_OP;
                    resp0_vld_d = ~grant_q;
                    resp1_vld_d = grant_q;
                end
            end
            ST_RESP: begin
                if (own_resp_rdy) begin
                    state_d     = ST_IDLE;
                    resp0_vld_d = 1'b0;
                    resp1_vld_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                opnd1_d     = '0;
                opnd2_d     = '0;
                op_d        = FPU_PARK_OP;
                resp0_vld_d = 1'b0;
                resp1_vld_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b1;
            result_q    <= '0;
            error_q     <= 1'b0;
            opnd1_q     <= '0;
            opnd2_q     <= '0;
            op_q        <= FPU_PARK_OP;
            resp0_vld_q <= 1'b0;
            resp1_vld_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            result_q    <= result_d;
            error_q     <= error_d;
            opnd1_q     <= opnd1_d;
            opnd2_q     <= opnd2_d;
            op_q        <= op_d;
            resp0_vld_q <= resp0_vld_d;
            resp1_vld_q <= resp1_vld_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req0_ready    = req_rdy_c[0];
    assign bus.req1_ready    = req_rdy_c[1];
    assign bus.resp0_valid   = resp0_vld_q;
    assign bus.resp1_valid   = resp1_vld_q;
    assign bus.resp0_result  = result_q;
    assign bus.resp1_result  = result_q;
    assign bus.resp0_error   = error_q;
    assign bus.resp1_error   = error_q;
    assign bus.fpu_operand_1 = opnd1_q;
    assign bus.fpu_operand_2 = opnd2_q;
    assign bus.fpu_operation = op_q;
    assign bus.busy          = busy_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Scoreboard bench for fpu_share_ctrl with a behavioural fixed-point unit model.
module tb_fpu_share_ctrl;
    import fpu_share_ctrl_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        bit          id;
        logic [31:0] res;
        bit          err;
    } sb_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_bad;
    sb_t  exp_q[$];

    // Unit model controls
    int   mdl_lat;
    bit   mdl_stale;
    bit   mdl_never;
    int   mdl_age;

    fpu_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

    fpu_share_ctrl #(
        .WIDTH   (WIDTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmodel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            FPU_ADD: return a + b;
            FPU_SUB: return a - b;
            FPU_MUL: return p[41:10];
            default: return a >> 1;
        endcase
    endfunction

    // Cycles since the operation was issued to the unit
    always @(posedge clk) begin
        if (reset || !bus.busy) mdl_age <= 0;
        else if (mdl_age < 1000) mdl_age <= mdl_age + 1;
    end

    // Unit model: optional stale ready in the first two cycles, then ready after mdl_lat
    always_comb begin
        bus.fpu_result = fmodel(bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2);
        bus.fpu_ready  = 1'b0;
        if (mdl_stale && mdl_age < 2) begin
            bus.fpu_ready  = 1'b1;
            bus.fpu_result = 32'hDEAD;
        end else if (!mdl_never) begin
            bus.fpu_ready = (mdl_age >= mdl_lat);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.resp0_valid && bus.resp1_valid) check_val("resp_excl", 2, 1);
            for (int p = 0; p < 2; p++) begin
                logic vld, rdy, err;
                logic [31:0] res;
                vld = (p == 0) ? bus.resp0_valid  : bus.resp1_valid;
                rdy = (p == 0) ? bus.resp0_ready  : bus.resp1_ready;
                res = (p == 0) ? bus.resp0_result : bus.resp1_result;
                err = (p == 0) ? bus.resp0_error  : bus.resp1_error;
                if (vld && rdy) begin
                    if (exp_q.size() == 0) begin
                        check_val("sb_unexpected", 64'(p), 64'hFF);
                    end else begin
                        sb_t e;
                        e = exp_q.pop_front();
                        check_val("sb_id", 64'(p), 64'(e.id));
                        check_val("sb_result", 64'(res), 64'(e.res));
                        check_val("sb_error", 64'(err), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic to_neg(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request, push its expectation on handshake, return the accept edge index
    task automatic send(input bit id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input bit exp_err,
                        output int acc);
        bit done;
        done = 0;
        acc  = -1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (id ? bus.req1_ready : bus.req0_ready) begin
                exp_q.push_back('{id: id, res: exp_res, err: exp_err});
                @(posedge clk);
                #1;
                acc  = cyc;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check_val("accept_timeout", 0, 1);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && exp_q.size() == 0) ok = 1;
        end
        if (!ok) check_val("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        int t0, t1, acc, rst_edge;
        cyc = 0; n_chk = 0; n_bad = 0;
        mdl_lat = 0; mdl_stale = 0; mdl_never = 0;
        reset = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_op = '0; bus.req1_op = '0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_busy", 64'(bus.busy), 0);
        check_val("rst_grant", 64'(bus.grant_id), 1);
        check_val("rst_op", 64'(bus.fpu_operation), 64'(FPU_ADD));
        check_val("rst_opnd1", 64'(bus.fpu_operand_1), 0);
        check_val("rst_vld0", 64'(bus.resp0_valid), 0);
        check_val("rst_vld1", 64'(bus.resp1_valid), 0);
        reset = 1'b0;
        @(negedge clk);

        // Tie right after reset: requester 0 first, then 1; repeated tie the same
        fork
            send(0, FPU_ADD, 32'h10, 32'h20, 32'h30, 0, t0);
            send(1, FPU_SUB, 32'h50, 32'h8, 32'h48, 0, t1);
        join
        check_val("tie1_order", 64'(t0 < t1), 1);
        wait_idle();
        fork
            send(0, FPU_MUL, 32'h800, 32'h800, 32'h1000, 0, t0);
            send(1, FPU_SQRT, 32'h900, 32'h0, fmodel(FPU_SQRT, 32'h900, 32'h0), 0, t1);
        join
        check_val("tie2_order", 64'(t0 < t1), 1);
        wait_idle();

        // Single ADD from requester 0: latency and registered unit operands
        send(0, FPU_ADD, 32'h600, 32'h800, 32'hE00, 0, acc);
        to_neg(1);
        check_val("add_opnd1", 64'(bus.fpu_operand_1), 64'h600);
        check_val("add_opnd2", 64'(bus.fpu_operand_2), 64'h800);
        check_val("add_op", 64'(bus.fpu_operation), 64'(FPU_ADD));
        check_val("add_busy", 64'(bus.busy), 1);
        to_neg(1);
        check_val("add_vld_early", 64'(bus.resp0_valid), 0);
        to_neg(1);
        check_val("add_vld_n3", 64'(bus.resp0_valid), 1);
        check_val("add_grant", 64'(bus.grant_id), 0);
        wait_idle();

        // Requester 0 won last, so a tie now goes to requester 1 first
        fork
            send(0, FPU_ADD, 32'h1, 32'h2, 32'h3, 0, t0);
            send(1, FPU_ADD, 32'h4, 32'h5, 32'h9, 0, t1);
        join
        check_val("tie3_rr", 64'(t1 < t0), 1);
        wait_idle();

        // MUL from requester 1 with 6-cycle unit latency; parking on RESP
        mdl_lat = 6;
        send(1, FPU_MUL, 32'h600, 32'h800, 32'hC00, 0, acc);
        to_neg(1);
        check_val("mul_op", 64'(bus.fpu_operation), 64'(FPU_MUL));
        to_neg(5);
        check_val("mul_vld_n6", 64'(bus.resp1_valid), 0);
        to_neg(1);
        check_val("mul_vld_n7", 64'(bus.resp1_valid), 1);
        check_val("mul_park_op", 64'(bus.fpu_operation), 64'(FPU_ADD));
        check_val("mul_park_opnd", 64'(bus.fpu_operand_1), 0);
        check_val("mul_grant", 64'(bus.grant_id), 1);
        wait_idle();

        // Stale ready during the settle window is ignored
        mdl_stale = 1; mdl_lat = 5;
        send(0, FPU_ADD, 32'h100, 32'h200, 32'h300, 0, acc);
        for (int k = 1; k <= 5; k++) begin
            to_neg(1);
            check_val("stale_vld_low", 64'(bus.resp0_valid), 0);
        end
        to_neg(1);
        check_val("stale_vld_n6", 64'(bus.resp0_valid), 1);
        wait_idle();
        mdl_stale = 0; mdl_lat = 0;

        // Timeout: no ready ever; response held while resp_ready is low
        mdl_never = 1;
        bus.resp0_ready = 1'b0;
        send(0, FPU_SUB, 32'h5, 32'h3, 32'h0, 1, acc);
        repeat (62) @(posedge clk);
        to_neg(1);
        check_val("to_vld_n63", 64'(bus.resp0_valid), 0);
        to_neg(1);
        check_val("to_vld_n64", 64'(bus.resp0_valid), 1);
        check_val("to_err", 64'(bus.resp0_error), 1);
        check_val("to_res", 64'(bus.resp0_result), 0);
        for (int k = 0; k < 10; k++) begin
            to_neg(1);
            check_val("to_hold", {bus.resp0_valid, bus.resp0_error, bus.resp0_result},
                      {1'b1, 1'b1, 32'h0});
        end
        @(posedge clk);
        #1 bus.resp0_ready = 1'b1;
        to_neg(1);
        check_val("to_idle", 64'(bus.busy), 0);
        check_val("to_vld_clr", 64'(bus.resp0_valid), 0);
        mdl_never = 0;
        wait_idle();

        // Reset during WAIT drops the operation; next request accepted at once
        mdl_never = 1;
        send(0, FPU_MUL, 32'h7, 32'h9, 32'h0, 0, acc);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_edge = cyc;
        check_val("mid_rst_busy", 64'(bus.busy), 0);
        check_val("mid_rst_op", 64'(bus.fpu_operation), 64'(FPU_ADD));
        check_val("mid_rst_vld", 64'(bus.resp0_valid), 0);
        reset = 1'b0;
        mdl_never = 0;
        send(0, FPU_ADD, 32'h1, 32'h2, 32'h3, 0, acc);
        check_val("mid_rst_accept", 64'(acc), 64'(rst_edge + 1));
        wait_idle();

        check_val("sb_drain", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
